dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate controller for the dcache line store (dcache_data_array).

---
 rtl/dcache_pkg.sv | 14 +
 rtl/dcache_tag_array.sv | 47 ++++
 rtl/dcache_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry for the direct-mapped data cache controller.
//   dcache_state_e : controller FSM states (CHECK, WRITEBACK, FILL)
//   S_OFFSET/S_INDEX/S_TAG : default address split (32 B lines, 8 sets, 24-bit tag)
//   LINE_BITS/MASK_W/WSEL_W : line width, per-byte mask width, word-select width
package dcache_pkg;
   localparam int S_OFFSET  = 5;
   localparam int S_INDEX   = 3;
   localparam int S_TAG     = 32 - S_OFFSET - S_INDEX;
   localparam int LINE_BITS = 256;
   localparam int MASK_W    = 32;
   localparam int WSEL_W    = 3;

   typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} dcache_state_e;
endpackage

// File: rtl/dcache_tag_array.sv
// dcache_tag_array: per-set tag/valid/dirty storage for the direct-mapped cache.
//   clk, rst        : clock, synchronous active-high reset (clears valid and dirty)
//   index           : set index used for both the read and the write port
//   load_tag/valid/dirty, tag_in/valid_in/dirty_in : independent write strobes and data
//   tag, valid, dirty : combinational read of the indexed set
module dcache_tag_array #(
   parameter int s_index = 3,
   parameter int s_tag   = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [s_index-1:0] index,
   input  logic               load_tag,
   input  logic               load_valid,
   input  logic               load_dirty,
   input  logic [s_tag-1:0]   tag_in,
   input  logic               valid_in,
   input  logic               dirty_in,
   output logic [s_tag-1:0]   tag,
   output logic               valid,
   output logic               dirty
);
   localparam int SETS = 1 << s_index;

   logic [s_tag-1:0] tags [SETS];
   logic [SETS-1:0]  valids;
   logic [SETS-1:0]  dirtys;

   // Tags need no reset: they are only meaningful behind a set valid bit.
   always_ff @(posedge clk) begin
      if (load_tag) tags[index] <= tag_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valids <= '0;
         dirtys <= '0;
      end else begin
         if (load_valid) valids[index] <= valid_in;
         if (load_dirty) dirtys[index] <= dirty_in;
      end
   end

   assign tag   = tags[index];
   assign valid = valids[index];
   assign dirty = dirtys[index];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
//   CPU side : mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable in,
//              mem_rdata/mem_resp out (hits respond in the request cycle)
//   Memory   : pmem_read/pmem_write/pmem_address/pmem_wdata out, pmem_rdata/pmem_resp in
//   Line store: da_rindex/da_windex/da_write_en/da_datain out, da_dataout in
// Optional feature macro DCACHE_PERF_CNT_EN adds hit_count/miss_count outputs.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int s_offset = S_OFFSET,
   parameter int s_index  = S_INDEX
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [31:0]          mem_address,
   input  logic [31:0]          mem_wdata,
   input  logic [3:0]           mem_byte_enable,
   output logic [31:0]          mem_rdata,
   output logic                 mem_resp,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic [31:0]          pmem_address,
   output logic [LINE_BITS-1:0] pmem_wdata,
   input  logic [LINE_BITS-1:0] pmem_rdata,
   input  logic                 pmem_resp,
   output logic [s_index-1:0]   da_rindex,
   output logic [s_index-1:0]   da_windex,
   output logic [MASK_W-1:0]    da_write_en,
   output logic [LINE_BITS-1:0] da_datain,
   input  logic [LINE_BITS-1:0] da_dataout
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0]          hit_count,
   output logic [31:0]          miss_count
`endif
);
   localparam int s_tag = 32 - s_offset - s_index;

   dcache_state_e          state;
   logic [31:s_offset]     miss_line;   // line address latched at the miss
   logic [31:s_offset]     cur_line;
   logic [s_tag-1:0]       req_tag, st_tag;
   logic [s_index-1:0]     idx;
   logic [WSEL_W-1:0]      word;
   logic                   st_valid, st_dirty;
   logic                   req, hit, fill_done;
   logic                   unused_addr_lsbs;

   assign unused_addr_lsbs = ^mem_address[1:0];

   // Outside CHECK the latched line address is used, so a dropped or
   // changing request cannot redirect an in-flight writeback/fill.
   assign cur_line  = (state == CHECK) ? mem_address[31:s_offset] : miss_line;
   assign req_tag   = cur_line[31:s_offset+s_index];
   assign idx       = cur_line[s_offset+s_index-1:s_offset];
   assign word      = mem_address[4:2];
   assign req       = mem_read | mem_write;
   assign hit       = (state == CHECK) && req && st_valid && (st_tag == req_tag);
   assign fill_done = (state == FILL) && pmem_resp && !rst;

   dcache_tag_array #(.s_index(s_index), .s_tag(s_tag)) u_tags (
      .clk        (clk),
      .rst        (rst),
      .index      (idx),
      .load_tag   (fill_done),
      .load_valid (fill_done),
      .load_dirty ((hit && mem_write) || fill_done),
      .tag_in     (req_tag),
      .valid_in   (1'b1),
      .dirty_in   (!fill_done),  // store hit sets, fill clears
      .tag        (st_tag),
      .valid      (st_valid),
      .dirty      (st_dirty)
   );

   assign da_rindex = idx;
   assign da_windex = idx;
   assign mem_resp  = hit;

   always_comb begin
      mem_rdata   = '0;
      da_write_en = '0;
      da_datain   = '0;
      if (hit && mem_read)
         mem_rdata = da_dataout[{word, 5'b0} +: 32];
      if (hit && mem_write) begin
         da_write_en = {{(MASK_W-4){1'b0}}, mem_byte_enable} << {word, 2'b00};
         da_datain   = {8{mem_wdata}};
      end else if (fill_done) begin
         da_write_en = '1;
         da_datain   = pmem_rdata;
      end
   end

   always_comb begin
      pmem_address = '0;
      pmem_wdata   = '0;
      if (pmem_write) begin
         pmem_address = {st_tag, idx, {s_offset{1'b0}}};
         pmem_wdata   = da_dataout;
      end else if (pmem_read) begin
         pmem_address = {req_tag, idx, {s_offset{1'b0}}};
      end
   end

   // pmem_read/pmem_write are registered alongside the state so they are
   // glitch-free and mutually exclusive.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CHECK;
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
         miss_line  <= '0;
      end else begin
         case (state)
            CHECK: if (req && !hit) begin
               miss_line <= mem_address[31:s_offset];
               if (st_valid && st_dirty) begin
                  state      <= WRITEBACK;
                  pmem_write <= 1'b1;
               end else begin
                  state     <= FILL;
                  pmem_read <= 1'b1;
               end
            end
            WRITEBACK: if (pmem_resp) begin
               state      <= FILL;
               pmem_write <= 1'b0;
               pmem_read  <= 1'b1;
            end
            FILL: if (pmem_resp) begin
               state     <= CHECK;
               pmem_read <= 1'b0;
            end
            default: begin
               state      <= CHECK;
               pmem_read  <= 1'b0;
               pmem_write <= 1'b0;
            end
         endcase
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   // refilled marks the first CHECK cycle after a fill, whose hit completes
   // a request already counted as a miss.
   logic refilled;
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
         refilled   <= 1'b0;
      end else begin
         if (state == CHECK) begin
            refilled <= 1'b0;
            if (hit && !refilled) hit_count  <= hit_count + 32'd1;
            if (req && !hit)      miss_count <= miss_count + 32'd1;
         end
         if (fill_done) refilled <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl. Models the line store and
// the memory adaptor, runs a directed vector table, a reset/drop sequence and a
// randomized run against a flat-memory reference plus a set-residency model.
module tb_dcache_ctrl;
   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read, mem_write;
   logic [31:0]  mem_address, mem_wdata;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_rdata;
   logic         mem_resp;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;
   logic [2:0]   da_rindex, da_windex;
   logic [31:0]  da_write_en;
   logic [255:0] da_datain, da_dataout;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0]  hit_count, miss_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int exp_hits = 0;
   int exp_misses = 0;

   dcache_ctrl dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .da_rindex(da_rindex), .da_windex(da_windex), .da_write_en(da_write_en),
      .da_datain(da_datain), .da_dataout(da_dataout)
`ifdef DCACHE_PERF_CNT_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   // Line store: combinational read with write bypass, byte-masked write.
   logic [255:0] lines [8];
   always_comb begin
      da_dataout = lines[da_rindex];
      for (int b = 0; b < 32; b++)
         if (da_write_en[b]) da_dataout[8*b +: 8] = da_datain[8*b +: 8];
   end
   always @(posedge clk) begin
      for (int b = 0; b < 32; b++)
         if (da_write_en[b]) lines[da_windex][8*b +: 8] <= da_datain[8*b +: 8];
   end

   function automatic logic [31:0] init_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w == 32'h40) return 32'hDEAD_BEEF;
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // Backing memory seen by the adaptor, and the CPU-visible reference memory.
   logic [31:0] pm [int unsigned];
   logic [31:0] rm [int unsigned];

   function automatic logic [31:0] pm_rd(input logic [31:0] a);
      return pm.exists(a >> 2) ? pm[a >> 2] : init_word(a);
   endfunction
   function automatic logic [31:0] rm_rd(input logic [31:0] a);
      return rm.exists(a >> 2) ? rm[a >> 2] : init_word(a);
   endfunction
   task automatic rm_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] w;
      w = rm_rd(a);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      rm[a >> 2] = w;
   endtask

   // Adaptor model: random 1..4 cycle latency, one-cycle pmem_resp.
   bit resp_en = 1'b1;
   int wait_cnt = 0;
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (resp_en) begin
            pmem_resp = 1'b0;
            if (pmem_read || pmem_write) begin
               if (wait_cnt == 0) wait_cnt = $urandom_range(1, 4);
               else begin
                  wait_cnt--;
                  if (wait_cnt == 0) begin
                     pmem_resp = 1'b1;
                     for (int i = 0; i < 8; i++) begin
                        if (pmem_write) pm[(pmem_address >> 2) + i] = pmem_wdata[32*i +: 32];
                        else pmem_rdata[32*i +: 32] = pm_rd(pmem_address + 32'(4*i));
                     end
                  end
               end
            end else wait_cnt = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // One CPU request; reports latency (cycles before mem_resp) and pmem activity.
   task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int lat, output bit saw_wb,
                         output logic [31:0] wb_addr, output bit saw_fill,
                         output logic [31:0] fill_addr, output logic [31:0] rdata,
                         output logic [31:0] wen);
      lat = 0; saw_wb = 0; saw_fill = 0; wb_addr = '0; fill_addr = '0; rdata = '0; wen = '0;
      @(negedge clk);
      mem_read = !wr; mem_write = wr; mem_address = a; mem_wdata = d; mem_byte_enable = be;
      forever begin
         #1;
         if (mem_resp) begin
            rdata = mem_rdata; wen = da_write_en;
            break;
         end
         if (pmem_write && !saw_wb) begin saw_wb = 1; wb_addr = pmem_address; end
         if (pmem_read && !saw_fill) begin saw_fill = 1; fill_addr = pmem_address; end
         lat++;
         if (lat > 300) begin
            chk("req_timeout", 32'(lat), 32'd0);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      mem_read = 0; mem_write = 0;
      if (lat == 0) exp_hits++; else exp_misses++;
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      bit          exp_hit, exp_wb;
      logic [31:0] exp_wb_addr, exp_fill_addr, exp_rdata, exp_wen;
   } vec_t;

   vec_t vt[5];
   int lat;
   bit saw_wb, saw_fill;
   logic [31:0] wb_addr, fill_addr, rdata, wen, w44;
   bit rv[8], rd[8];
   logic [31:0] rl[8];

   initial begin
      rst = 1; mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
      w44 = init_word(32'h44);
      vt[0] = '{0, 32'h40,  0, 4'h0, 0, 0, 0, 32'h40,  32'hDEAD_BEEF, 0};
      vt[1] = '{1, 32'h44,  32'h1122_3344, 4'b0011, 1, 0, 0, 0, 0, 32'h0000_0030};
      vt[2] = '{0, 32'h44,  0, 4'h0, 1, 0, 0, 0, {w44[31:16], 16'h3344}, 0};
      vt[3] = '{0, 32'h140, 0, 4'h0, 0, 1, 32'h40, 32'h140, init_word(32'h140), 0};
      vt[4] = '{0, 32'h240, 0, 4'h0, 0, 0, 0, 32'h240, init_word(32'h240), 0};

      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_resp", 32'(mem_resp), 0);
      chk("rst_pmem_rw", {30'b0, pmem_read, pmem_write}, 0);
      chk("rst_da_write_en", da_write_en, 0);
      chk("rst_pmem_address", pmem_address, 0);
      rst = 0;

      // Directed table.
      for (int i = 0; i < 5; i++) begin
         do_req(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be, lat, saw_wb, wb_addr,
                saw_fill, fill_addr, rdata, wen);
         if (vt[i].wr) rm_store(vt[i].addr, vt[i].wdata, vt[i].be);
         chk($sformatf("vec%0d_hit", i), 32'(lat == 0), 32'(vt[i].exp_hit));
         if (!vt[i].exp_hit) begin
            chk($sformatf("vec%0d_wb", i), 32'(saw_wb), 32'(vt[i].exp_wb));
            if (vt[i].exp_wb) chk($sformatf("vec%0d_wb_addr", i), wb_addr, vt[i].exp_wb_addr);
            chk($sformatf("vec%0d_fill_addr", i), fill_addr, vt[i].exp_fill_addr);
         end
         if (vt[i].wr) chk($sformatf("vec%0d_wen", i), wen, vt[i].exp_wen);
         else          chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rdata);
      end
      chk("wb_mem_0x44", pm_rd(32'h44), {w44[31:16], 16'h3344});

      // Reset during FILL coinciding with pmem_resp.
      resp_en = 0;
      @(negedge clk);
      mem_read = 1; mem_address = 32'h40;
      @(negedge clk); #1;
      chk("rstfill_pmem_read", 32'(pmem_read), 1);
      pmem_rdata = {8{32'hBAD0_BAD0}}; pmem_resp = 1; rst = 1;
      @(negedge clk);
      pmem_resp = 0; rst = 0;
      exp_hits = 0; exp_misses = 0;
      #1;
      chk("rstfill_pmem_read_after", 32'(pmem_read), 0);
      chk("rstfill_no_resp", 32'(mem_resp), 0);
      @(negedge clk); #1;
      exp_misses++;
      chk("rstfill_remiss", 32'(pmem_read), 1);
      chk("rstfill_remiss_addr", pmem_address, 32'h40);
      // Drop the request mid-fill: fill still completes, no response.
      mem_read = 0; wait_cnt = 0; resp_en = 1;
      begin
         bit got_resp;
         int n;
         got_resp = 0; n = 0;
         while ((pmem_read || pmem_write) && n < 50) begin
            @(negedge clk); #1;
            if (mem_resp) got_resp = 1;
            n++;
         end
         repeat (2) begin @(negedge clk); #1; if (mem_resp) got_resp = 1; end
         chk("drop_done", 32'(n < 50), 1);
         chk("drop_no_resp", 32'(got_resp), 0);
      end
      do_req(0, 32'h40, 0, 0, lat, saw_wb, wb_addr, saw_fill, fill_addr, rdata, wen);
      chk("after_drop_hit", 32'(lat == 0), 1);
      chk("after_drop_rdata", rdata, 32'hDEAD_BEEF);

      // Randomized run against the residency model and reference memory.
      for (int s = 0; s < 8; s++) begin rv[s] = 0; rd[s] = 0; rl[s] = '0; end
      rv[2] = 1; rl[2] = 32'h40;
      for (int k = 0; k < 150; k++) begin
         logic [31:0] a, d, la;
         logic [3:0]  be;
         bit wr, eh, ew;
         int s;
         a  = 32'($urandom_range(0, 255)) << 2;
         d  = $urandom;
         be = 4'($urandom_range(0, 15));
         wr = 1'($urandom_range(0, 1));
         s  = int'(a[7:5]);
         la = {a[31:5], 5'b0};
         eh = rv[s] && (rl[s] == la);
         ew = !eh && rv[s] && rd[s];
         do_req(wr, a, d, be, lat, saw_wb, wb_addr, saw_fill, fill_addr, rdata, wen);
         chk($sformatf("rnd%0d_hit", k), 32'(lat == 0), 32'(eh));
         if (!eh) begin
            chk($sformatf("rnd%0d_wb", k), 32'(saw_wb), 32'(ew));
            if (ew) chk($sformatf("rnd%0d_wb_addr", k), wb_addr, rl[s]);
            chk($sformatf("rnd%0d_fill_addr", k), fill_addr, la);
         end
         if (wr) begin
            chk($sformatf("rnd%0d_wen", k), wen, 32'(be) << (4 * a[4:2]));
            rm_store(a, d, be);
         end else chk($sformatf("rnd%0d_rdata", k), rdata, rm_rd(a));
         rv[s] = 1; rl[s] = la;
         if (!eh) rd[s] = 0;
         if (wr) rd[s] = 1;
      end

`ifdef DCACHE_PERF_CNT_EN
      @(negedge clk); #1;
      chk("hit_count", hit_count, 32'(exp_hits));
      chk("miss_count", miss_count, 32'(exp_misses));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
